// File: rtl/tsr_run_ctrl.sv
// Frame run controller for the TSR classifier: sequences weight load, pixel streaming
// and result hand-off, exposes status over AXI-lite reads and issues a soft-reset pulse.
module tsr_run_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH   = 20,
    parameter int unsigned PIXELS           = 1024,
    parameter int unsigned RST_CYCLES       = 16,
    parameter int unsigned OFFSET_OUTPUT    = 'h0C00,
    parameter int unsigned OFFSET_OVALID    = 'h0C01,
    parameter int unsigned OFFSET_BUSY      = 'h0C09,
    parameter int unsigned OFFSET_RESET     = 'h0C11,
    parameter int unsigned OFFSET_CLOCK_CNT = 'h9_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
    input  logic [63:0]               axi_wr_data,
    input  logic                      axi_wr_en,
    input  logic [7:0]                axi_wr_strobe,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
    input  logic                      axi_rd_en,
    output logic [63:0]               axi_rd_data,
    input  logic                      weight_load_done,
    input  logic                      pixel_rd,
    input  logic                      model_o_valid,
    input  logic [5:0]                model_o_data,
    output logic                      soft_rst_n,
    output logic                      busy,
    output logic                      done,
    output logic [5:0]                result,
    output logic                      err
);

    localparam int unsigned PIX_W = $clog2(PIXELS + 1);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned RES_W = 6;

    typedef enum logic [1:0] {
        WAIT_W = 2'd0,
        IDLE   = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic               soft_rst_n_q, soft_rst_n_d;

    logic               rst_wr;
    logic               rst_start;
    logic               pulse_active;
    logic               soft_clr;
    logic               ovalid_rd;
    logic               unused_wr_bits;

    assign unused_wr_bits = ^{axi_wr_data[63:1], axi_wr_strobe[7:1]};

    assign rst_wr = axi_wr_en
                 && (axi_wr_addr == AXI_ADDR_WIDTH'(OFFSET_RESET))
                 && axi_wr_strobe[0]
                 && axi_wr_data[0];

    assign pulse_active = (rst_cnt_q != '0);
    // A trigger while a pulse is running is dropped so the pulse is never stretched.
    assign rst_start    = rst_wr && !pulse_active;
    assign soft_clr     = rst_start || pulse_active;

    assign ovalid_rd = axi_rd_en && (axi_rd_addr == AXI_ADDR_WIDTH'(OFFSET_OVALID));

    // Soft-reset pulse generator: low for RST_CYCLES cycles starting the cycle after the trigger.
    always_comb begin
        rst_cnt_d    = rst_cnt_q;
        soft_rst_n_d = soft_rst_n_q;
        if (rst_start) begin
            rst_cnt_d    = RST_W'(RST_CYCLES);
            soft_rst_n_d = 1'b0;
        end else if (pulse_active) begin
            rst_cnt_d    = rst_cnt_q - RST_W'(1);
            soft_rst_n_d = (rst_cnt_q == RST_W'(1));
        end
    end

    // Run FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        done_d      = done_q;
        result_d    = result_q;
        err_d       = err_q;

        if (soft_clr) begin
            state_d     = WAIT_W;
            cycle_cnt_d = '0;
            pix_cnt_d   = '0;
            done_d      = 1'b0;
            result_d    = '0;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_W: begin
                    if (pixel_rd || model_o_valid) begin
                        err_d = 1'b1;
                    end
                    if (weight_load_done) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (model_o_valid) begin
                        err_d = 1'b1;
                    end
                    if (pixel_rd) begin
                        state_d     = RUN;
                        cycle_cnt_d = '0;
                        pix_cnt_d   = PIX_W'(1);
                    end
                end
                RUN: begin
                    if (pixel_rd) begin
                        if (pix_cnt_q == PIX_W'(PIXELS)) begin
                            err_d = 1'b1;
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end
                    // The classification pulse freezes the cycle count at its arrival.
                    if (model_o_valid) begin
                        result_d = model_o_data;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (cycle_cnt_q != '1) begin
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (model_o_valid) begin
                        err_d = 1'b1;
                    end
                    if (pixel_rd) begin
                        state_d     = RUN;
                        cycle_cnt_d = '0;
                        pix_cnt_d   = PIX_W'(1);
                        done_d      = 1'b0;
                    end else if (ovalid_rd) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = WAIT_W;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_W;
            cycle_cnt_q  <= '0;
            pix_cnt_q    <= '0;
            done_q       <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rst_cnt_q    <= '0;
            soft_rst_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            done_q       <= done_d;
            result_q     <= result_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rst_cnt_q    <= rst_cnt_d;
            soft_rst_n_q <= soft_rst_n_d;
        end
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        axi_rd_data = '0;
        if (axi_rd_addr == AXI_ADDR_WIDTH'(OFFSET_OUTPUT)) begin
            axi_rd_data = 64'(result_q);
        end else if (axi_rd_addr == AXI_ADDR_WIDTH'(OFFSET_OVALID)) begin
            axi_rd_data = 64'(done_q);
        end else if (axi_rd_addr == AXI_ADDR_WIDTH'(OFFSET_BUSY)) begin
            axi_rd_data = 64'(busy_q);
        end else if (axi_rd_addr == AXI_ADDR_WIDTH'(OFFSET_CLOCK_CNT)) begin
            axi_rd_data = 64'(cycle_cnt_q);
        end
    end

    assign soft_rst_n = soft_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tsr_run_ctrl.sv
// Directed bench for tsr_run_ctrl: frame flow, read-clear, soft reset, error cases,
// counter saturation and asynchronous reset, with hand-computed expectations.
module tb_tsr_run_ctrl;

    localparam int unsigned AW = 20;
    localparam logic [AW-1:0] A_OUTPUT = 20'h00C00;
    localparam logic [AW-1:0] A_OVALID = 20'h00C01;
    localparam logic [AW-1:0] A_BUSY   = 20'h00C09;
    localparam logic [AW-1:0] A_RESET  = 20'h00C11;
    localparam logic [AW-1:0] A_CLK    = 20'h90000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] axi_wr_addr;
    logic [63:0]   axi_wr_data;
    logic          axi_wr_en;
    logic [7:0]    axi_wr_strobe;
    logic [AW-1:0] axi_rd_addr;
    logic          axi_rd_en;
    logic [63:0]   axi_rd_data;
    logic          weight_load_done;
    logic          pixel_rd;
    logic          model_o_valid;
    logic [5:0]    model_o_data;
    logic          soft_rst_n;
    logic          busy;
    logic          done;
    logic [5:0]    result;
    logic          err;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    tsr_run_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_wr_addr     (axi_wr_addr),
        .axi_wr_data     (axi_wr_data),
        .axi_wr_en       (axi_wr_en),
        .axi_wr_strobe   (axi_wr_strobe),
        .axi_rd_addr     (axi_rd_addr),
        .axi_rd_en       (axi_rd_en),
        .axi_rd_data     (axi_rd_data),
        .weight_load_done(weight_load_done),
        .pixel_rd        (pixel_rd),
        .model_o_valid   (model_o_valid),
        .model_o_data    (model_o_data),
        .soft_rst_n      (soft_rst_n),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .err             (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [AW-1:0] addr, input logic [63:0] exp);
        axi_rd_addr = addr;
        #1;
        chk(tag, axi_rd_data, exp);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [63:0] data, input logic [7:0] strb);
        axi_wr_addr   = addr;
        axi_wr_data   = data;
        axi_wr_strobe = strb;
        axi_wr_en     = 1'b1;
        tick(1);
        axi_wr_en     = 1'b0;
    endtask

    // Counts consecutive sampled cycles with soft_rst_n low, bounded to 40.
    task automatic count_low(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (soft_rst_n !== 1'b0) break;
            cnt++;
            tick(1);
        end
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst_n = 1'b1; axi_wr_addr = '0; axi_wr_data = '0; axi_wr_en = 1'b0;
        axi_wr_strobe = '0; axi_rd_addr = '0; axi_rd_en = 1'b0;
        weight_load_done = 1'b0; pixel_rd = 1'b0; model_o_valid = 1'b0; model_o_data = '0;

        // Power-on reset values.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_srn", soft_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk_rd("rst_clkcnt", A_CLK, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);
        chk("rst_release_no_pulse", soft_rst_n, 1);

        // pixel_rd while waiting for weights.
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        chk("err_pix_wait_w", err, 1);
        chk("busy_wait_w", busy, 0);
        tick(3);
        chk("err_sticky_wait_w", err, 1);

        // Reset writes that must not trigger.
        wr(A_RESET, 64'h0, 8'h01);
        chk("srst_data0", soft_rst_n, 1);
        wr(A_RESET, 64'h1, 8'h02);
        chk("srst_strb0", soft_rst_n, 1);
        wr(A_OVALID, 64'h1, 8'h01);
        chk("srst_wrong_addr", soft_rst_n, 1);
        tick(1);
        chk("srst_nop_err_kept", err, 1);

        // Plain soft reset clears err.
        wr(A_RESET, 64'h1, 8'h01);
        chk("srst_low", soft_rst_n, 0);
        chk("srst_err_clr", err, 0);
        count_low(n);
        chk("srst_len", 64'(n), 16);
        chk("srst_after_err", err, 0);

        // Normal frame: 1024 pixels, result 17 when cycle_cnt shows 1500.
        weight_load_done = 1'b1;
        tick(1);
        chk_rd("idle_busy_rd", A_BUSY, 0);
        pixel_rd = 1'b1; tick(1);
        chk("run_busy", busy, 1);
        chk_rd("run_clk0", A_CLK, 0);
        model_o_data = 6'd17;
        for (int k = 0; k <= 1500; k++) begin
            pixel_rd      = (k < 1023);
            model_o_valid = (k == 1500);
            if (k == 1499) begin
                chk("frame_busy_pre", busy, 1);
                chk_rd("frame_clk1499", A_CLK, 1499);
            end
            tick(1);
        end
        pixel_rd = 1'b0; model_o_valid = 1'b0;
        chk("frame_busy_post", busy, 0);
        chk("frame_done", done, 1);
        chk("frame_result", result, 17);
        chk("frame_err", err, 0);
        chk_rd("frame_clkcnt", A_CLK, 1500);
        chk_rd("frame_out_rd", A_OUTPUT, 17);
        chk_rd("frame_busy_rd", A_BUSY, 0);
        tick(3);
        chk_rd("frame_clk_frozen", A_CLK, 1500);

        // Read-clear of done.
        axi_rd_en = 1'b1; axi_rd_addr = A_OVALID; #1;
        chk("rc_first_read", axi_rd_data, 1);
        tick(1); axi_rd_en = 1'b0;
        chk("rc_done_clr", done, 0);
        chk_rd("rc_second_read", A_OVALID, 0);
        chk("rc_idle_busy", busy, 0);
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        chk("rc_idle_to_run", busy, 1);
        model_o_valid = 1'b1; model_o_data = 6'd42; tick(1); model_o_valid = 1'b0;
        chk("rc_done2", done, 1);
        chk("rc_result2", result, 42);
        chk_rd("rc_clk_frozen0", A_CLK, 0);
        // pixel_rd wins over a simultaneous OVALID read.
        pixel_rd = 1'b1; axi_rd_en = 1'b1; axi_rd_addr = A_OVALID; #1;
        chk("rc_simul_read", axi_rd_data, 1);
        tick(1); axi_rd_en = 1'b0;
        chk("rc_simul_busy", busy, 1);
        chk("rc_simul_done", done, 0);
        pixel_rd = 1'b0;
        tick(2);
        chk_rd("rc_clk_reload", A_CLK, 2);

        // Pixel overflow: 1023 more pixels reach 1024, the next one is an error.
        pixel_rd = 1'b1; tick(1023); pixel_rd = 1'b0;
        chk("pix1024_no_err", err, 0);
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        chk("pix1025_err", err, 1);
        chk("pix1025_busy", busy, 1);
        model_o_valid = 1'b1; model_o_data = 6'd3; tick(1); model_o_valid = 1'b0;
        chk("pix_done", done, 1);
        chk("pix_err_sticky", err, 1);
        axi_rd_en = 1'b1; axi_rd_addr = A_OVALID; tick(1); axi_rd_en = 1'b0;
        chk("pix_back_idle", done, 0);

        // Soft reset mid-RUN, second trigger during the pulse is ignored.
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        chk("srun_busy", busy, 1);
        weight_load_done = 1'b0;
        wr(A_RESET, 64'h1, 8'h01);
        chk("srun_low", soft_rst_n, 0);
        chk("srun_busy_clr", busy, 0);
        chk("srun_err_clr", err, 0);
        chk("srun_result_clr", result, 0);
        chk_rd("srun_clk_clr", A_CLK, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (soft_rst_n !== 1'b0) break;
            n++;
            axi_wr_en = (i == 5);
            tick(1);
        end
        axi_wr_en = 1'b0;
        chk("srun_no_extend", 64'(n), 16);
        chk("srun_after_busy", busy, 0);
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        chk("srun_wait_w_err", err, 1);
        chk("srun_wait_w_busy", busy, 0);

        // model_o_valid while IDLE.
        weight_load_done = 1'b1;
        wr(A_RESET, 64'h1, 8'h01);
        count_low(n);
        chk("clr_err", err, 0);
        tick(1);
        model_o_valid = 1'b1; model_o_data = 6'd9; tick(1); model_o_valid = 1'b0;
        chk("valid_idle_err", err, 1);
        chk("valid_idle_done", done, 0);
        chk("valid_idle_result", result, 0);
        tick(4);
        chk("valid_idle_sticky", err, 1);
        chk_rd("unmapped_c02", 20'h00C02, 0);
        chk_rd("unmapped_0", 20'h00000, 0);

        // Cycle counter saturation.
        pixel_rd = 1'b1; tick(1); pixel_rd = 1'b0;
        @(negedge clk);
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.cycle_cnt_q;
        tick(5);
        chk_rd("sat_clkcnt", A_CLK, 64'hFFFF_FFFF);
        chk("sat_busy", busy, 1);

        // Asynchronous reset while running.
        #2 rst_n = 1'b0;
        #1;
        chk("arun_busy", busy, 0);
        chk("arun_err", err, 0);
        chk("arun_done", done, 0);
        chk("arun_result", result, 0);
        chk("arun_srn", soft_rst_n, 1);
        chk_rd("arun_clk", A_CLK, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);

        // Asynchronous reset in the middle of a soft-reset pulse.
        wr(A_RESET, 64'h1, 8'h01);
        tick(3);
        chk("apulse_low", soft_rst_n, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("apulse_srn", soft_rst_n, 1);
        chk("apulse_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(20);
        chk("apulse_aborted", soft_rst_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
